// File: rtl/lifo_stack.sv
// Parametrised LIFO stack for WIDTH-bit count values with occupancy outputs
// and sticky overflow/underflow flags. The level register doubles as the write index.
module lifo_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 5,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LW-1:0]    level,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    level_q;
    logic             overflow_q;
    logic             underflow_q;

    logic             wr_en;
    logic [LW-1:0]    wr_idx;
    logic [LW-1:0]    level_d;
    logic             set_ovf;
    logic             set_unf;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));

    // Push+pop on a non-empty stack overwrites the top in place; on an empty
    // stack it degrades to a plain push.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = level_q;
        level_d = level_q;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = level_q - LW'(1);
        end else if (push) begin
            if (full) begin
                set_ovf = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_idx  = level_q;
                level_d = level_q + LW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                set_unf = 1'b1;
            end else begin
                level_d = level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            overflow_q  <= overflow_q | set_ovf;
            underflow_q <= underflow_q | set_unf;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && wr_idx == LW'(i)) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    // Top-of-stack read mux; zero whenever the stack is empty.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_q == LW'(i + 1)) begin
                rdata = mem[i];
            end
        end
    end

    assign level     = level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack: a queue-based stack model predicts the
// registered outputs after every cycle and a monitor compares them.
module tb_lifo_stack;

    localparam int WIDTH = 12;
    localparam int DEPTH = 5;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int EW    = WIDTH + LW + 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic [WIDTH-1:0] rdata;
    logic [LW-1:0]    level;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop),
        .wdata(wdata), .rdata(rdata), .level(level), .empty(empty),
        .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    logic [EW-1:0]    exp_q[$];
    logic [WIDTH-1:0] stk[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               cyc = 0;

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic r, input logic c, input logic pu,
                        input logic po, input logic [WIDTH-1:0] wd);
        logic [WIDTH-1:0] top;
        int               sz;
        @(negedge clk);
        rst = r; clear = c; push = pu; pop = po; wdata = wd;
        if (r || c) begin
            stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (pu && po) begin
            if (stk.size() == 0) stk.push_back(wd);
            else stk[stk.size()-1] = wd;
        end else if (pu) begin
            if (stk.size() == DEPTH) m_ovf = 1'b1;
            else stk.push_back(wd);
        end else if (po) begin
            if (stk.size() == 0) m_unf = 1'b1;
            else void'(stk.pop_back());
        end
        sz  = stk.size();
        top = (sz == 0) ? '0 : stk[sz-1];
        exp_q.push_back({top, LW'(sz), sz == 0, sz == DEPTH, m_ovf, m_unf});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: outputs are presented every cycle, compare 1 time unit after the edge.
    initial begin
        logic [EW-1:0] got, want;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {rdata, level, empty, full, overflow, underflow};
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL outputs cyc=%0d: got rdata=%h level=%0d empty=%b full=%b ovf=%b unf=%b, want rdata=%h level=%0d empty=%b full=%b ovf=%b unf=%b",
                             cyc, got[EW-1 -: WIDTH], got[LW+3:4], got[3], got[2], got[1], got[0],
                             want[EW-1 -: WIDTH], want[LW+3:4], want[3], want[2], want[1], want[0]);
                end
            end
        end
    end

    initial begin
        logic r, c, pu, po;
        // Reset, then fill 0x101..0x105 and overflow with 0xABC.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, WIDTH'(12'h100 + i));
        step(1'b0, 1'b0, 1'b1, 1'b0, 12'hABC);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 12'h3C3);
        // Drain and underflow.
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, WIDTH'(12'h100 + i));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        // Replace top, then replace at full.
        step(1'b0, 1'b0, 1'b1, 1'b0, 12'h010);
        step(1'b0, 1'b0, 1'b1, 1'b0, 12'h020);
        step(1'b0, 1'b0, 1'b1, 1'b1, 12'h7FF);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, WIDTH'(12'h200 + i));
        step(1'b0, 1'b0, 1'b1, 1'b1, 12'h001);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        // Push+pop on empty.
        step(1'b0, 1'b0, 1'b1, 1'b1, 12'h055);
        // Reset mid-operation with underflow set.
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, WIDTH'(12'h300 + i));
        step(1'b1, 1'b0, 1'b1, 1'b0, 12'hFFF);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        // Randomized traffic: a push-biased phase then a pop-biased phase.
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            c  = ($urandom_range(0, 99) < 3);
            pu = (i < 300) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 35);
            po = (i < 300) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 70);
            step(r, c, pu, po, WIDTH'($urandom));
        end
        idle();
        // Bounded drain of the expectation queue.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
